reg_bus_adapter: RTL and testbench

- Bus-side responder that converts a valid/ready command/response bus into the generic per-register strobe interface consumed by the register map.
- Decodes the word address, issues single-cycle write_en/read_en strobes, captures read data, and returns a response with an error flag.
- Sits between the SoC interconnect and the peripheral's register map, one instance per peripheral.

---
 rtl/reg_bus_pkg.sv | 32 +++
 rtl/reg_bus_adapter.sv | 187 ++++++++++++++++++
 tb/tb_reg_bus_adapter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_pkg
// Shared types and helpers for the register-bus adapter.
//   reg_bus_state_t : adapter FSM states (IDLE, ACCESS, RESPOND)
//   REG_DATA_W      : register data width
//   STROBE_MAX_W    : widest strobe vector onehot_decode can produce
//   onehot_decode   : address -> one-hot strobe, all-zero when addr >= n
// -----------------------------------------------------------------------------
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } reg_bus_state_t;

  localparam int REG_DATA_W   = 32;
  localparam int STROBE_MAX_W = 256;

  // Full-width compare: an address only selects bit i when it equals i
  // exactly and lies below n, so out-of-range addresses never alias.
  function automatic logic [STROBE_MAX_W-1:0] onehot_decode(input logic [31:0] addr,
                                                            input logic [31:0] n);
    logic [STROBE_MAX_W-1:0] vec;
    vec = {STROBE_MAX_W{1'b0}};
    for (int i = 0; i < STROBE_MAX_W; i++) begin
      vec[i] = (addr == 32'(i)) && (addr < n);
    end
    return vec;
  endfunction

endpackage

// File: rtl/reg_bus_adapter.sv
// -----------------------------------------------------------------------------
// reg_bus_adapter
// Converts a valid/ready command/response bus into single-cycle per-register
// write/read strobes for a peripheral register map. One transaction in flight.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (cmd_ready registered)
//   cmd_write           : 1 = write, 0 = read
//   cmd_addr            : word address (ADDR_W bits)
//   cmd_wdata           : write data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : read data (0 for writes and errors)
//   rsp_error           : address >= REGS
//   write_en, read_en   : one-hot strobes, asserted only in ACCESS
//   data_in             : write data to the register map (ACCESS-write only)
//   data_out            : packed register read values, reg k at [32k+31:32k]
// -----------------------------------------------------------------------------
module reg_bus_adapter
  import reg_bus_pkg::*;
#(
  parameter int REGS         = 5,
  parameter int POWEROF2REGS = 1 << $clog2(REGS),
  parameter int ADDR_W       = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [ADDR_W-1:0]                  cmd_addr,
  input  logic [REG_DATA_W-1:0]              cmd_wdata,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [REG_DATA_W-1:0]              rsp_rdata,
  output logic                               rsp_error,
  output logic [POWEROF2REGS-1:0]            write_en,
  output logic [POWEROF2REGS-1:0]            read_en,
  output logic [REG_DATA_W-1:0]              data_in,
  input  logic [POWEROF2REGS*REG_DATA_W-1:0] data_out
);

  reg_bus_state_t state_r;
  reg_bus_state_t next_state_s;

  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic [REG_DATA_W-1:0]   rsp_rdata_r;
  logic                    rsp_error_r;
  logic [POWEROF2REGS-1:0] write_en_r;
  logic [POWEROF2REGS-1:0] read_en_r;
  logic [REG_DATA_W-1:0]   data_in_r;

  logic                    write_r;
  logic [ADDR_W-1:0]       addr_r;

  logic                    accept_s;
  logic                    rsp_hs_s;
  logic                    cmd_addr_ok_s;
  logic                    addr_ok_s;
  logic [POWEROF2REGS-1:0] cmd_strobe_s;
  logic [REG_DATA_W-1:0]   rd_word_s;

  assign accept_s      = (state_r == IDLE) && cmd_valid && cmd_ready_r;
  assign rsp_hs_s      = (state_r == RESPOND) && rsp_valid_r && rsp_ready;
  assign cmd_addr_ok_s = (32'(cmd_addr) < 32'(REGS));
  assign addr_ok_s     = (32'(addr_r) < 32'(REGS));
  assign cmd_strobe_s  = POWEROF2REGS'(onehot_decode(32'(cmd_addr), 32'(REGS)));

  // Read-data mux: pick the word addressed by the latched command.
  always_comb begin
    rd_word_s = {REG_DATA_W{1'b0}};
    for (int k = 0; k < POWEROF2REGS; k++) begin
      rd_word_s = rd_word_s |
                  ({REG_DATA_W{addr_r == ADDR_W'(k)}} & data_out[k*REG_DATA_W +: REG_DATA_W]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; ACCESS always lasts exactly one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        next_state_s = RESPOND;
      end
      RESPOND: begin
        if (rsp_hs_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESPOND;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Command capture: hold direction and address for the ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      write_r <= cmd_write;
      addr_r  <= cmd_addr;
    end else begin
      write_r <= write_r;
      addr_r  <= addr_r;
    end
  end

  // cmd_ready follows the state we are entering, so it is high exactly in IDLE
  // except for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready_r <= 1'b0;
    end else begin
      cmd_ready_r <= (next_state_s == IDLE);
    end
  end

  // Strobes and write data are loaded on the accept edge so that they are
  // high for the ACCESS cycle only and drop on the edge that leaves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_en_r <= {POWEROF2REGS{1'b0}};
      read_en_r  <= {POWEROF2REGS{1'b0}};
      data_in_r  <= {REG_DATA_W{1'b0}};
    end else if (accept_s) begin
      write_en_r <= cmd_write ? cmd_strobe_s : {POWEROF2REGS{1'b0}};
      read_en_r  <= cmd_write ? {POWEROF2REGS{1'b0}} : cmd_strobe_s;
      data_in_r  <= (cmd_write && cmd_addr_ok_s) ? cmd_wdata : {REG_DATA_W{1'b0}};
    end else begin
      write_en_r <= {POWEROF2REGS{1'b0}};
      read_en_r  <= {POWEROF2REGS{1'b0}};
      data_in_r  <= {REG_DATA_W{1'b0}};
    end
  end

  // Response register: read data is sampled at the end of ACCESS, i.e. the
  // value the map presented while the strobe was high (before any pop).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {REG_DATA_W{1'b0}};
      rsp_error_r <= 1'b0;
    end else if (state_r == ACCESS) begin
      rsp_valid_r <= 1'b1;
      rsp_error_r <= !addr_ok_s;
      rsp_rdata_r <= (!write_r && addr_ok_s) ? rd_word_s : {REG_DATA_W{1'b0}};
    end else if (rsp_hs_s) begin
      rsp_valid_r <= 1'b0;
      rsp_error_r <= 1'b0;
      rsp_rdata_r <= {REG_DATA_W{1'b0}};
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_error_r <= rsp_error_r;
      rsp_rdata_r <= rsp_rdata_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;
  assign write_en  = write_en_r;
  assign read_en   = read_en_r;
  assign data_in   = data_in_r;

endmodule

// File: tb/tb_reg_bus_adapter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_adapter
// Self-checking bench: directed table, hand-written corner sequences, then
// random transactions against a simple register-file/FIFO reference model.
// -----------------------------------------------------------------------------
module tb_reg_bus_adapter;

  localparam int REGS   = 5;
  localparam int P2     = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic [P2-1:0]     write_en;
  logic [P2-1:0]     read_en;
  logic [31:0]       data_in;
  logic [P2*32-1:0]  data_out;

  int checks = 0;
  int errors = 0;

  reg_bus_adapter #(.REGS(REGS), .POWEROF2REGS(P2), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Register map stand-in: plain registers, except address 4 is a FIFO whose
  // head advances on every read strobe.
  function automatic logic [31:0] fifo_val(input int idx);
    return 32'h0000_00AA + 32'h0000_0011 * 32'(idx);
  endfunction

  logic [31:0] map_regs [0:P2-1];
  int          fifo_rd;
  logic        map_init;

  always @(posedge clk) begin
    if (map_init) begin
      for (int k = 0; k < P2; k++) map_regs[k] <= 32'h0;
      fifo_rd <= 0;
    end else begin
      for (int k = 0; k < P2; k++) begin
        if (write_en[k] && k != 4) map_regs[k] <= data_in;
      end
      if (read_en[4]) fifo_rd <= fifo_rd + 1;
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < P2; k++) begin
      data_out[k*32 +: 32] = (k == 4) ? fifo_val(fifo_rd) : map_regs[k];
    end
  end

  // Reference model of the register map contents as seen by the requester.
  logic [31:0] model_regs [0:P2-1];
  int          model_fifo_rd = 0;

  function automatic logic [31:0] model_rdata(input bit wr, input logic [7:0] addr);
    if (wr || addr >= REGS) return 32'h0;
    if (addr == 4) return fifo_val(model_fifo_rd);
    return model_regs[addr];
  endfunction

  task automatic model_update(input bit wr, input logic [7:0] addr, input logic [31:0] wdata);
    if (wr && addr < REGS && addr != 4) model_regs[addr] = wdata;
    if (!wr && addr == 4) model_fifo_rd++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction. Called just after a falling edge with cmd_valid low.
  task automatic txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit exp_err,
                     input int hold, input bit second_cmd);
    int waits;
    int lat;
    int extra;
    bit ok;
    logic [7:0] exp_we;
    logic [7:0] exp_re;
    ok     = (addr < REGS);
    exp_we = (wr && ok) ? (8'h01 << addr[2:0]) : 8'h00;
    exp_re = (!wr && ok) ? (8'h01 << addr[2:0]) : 8'h00;
    extra  = 0;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) check("accept_timeout", 32'(waits), 32'd0);
    @(negedge clk);
    cmd_valid = second_cmd;
    cmd_addr  = 8'h01;
    check("write_en", 32'(write_en), 32'(exp_we));
    check("read_en", 32'(read_en), 32'(exp_re));
    if (!(wr && !ok)) check("data_in", data_in, (wr && ok) ? wdata : 32'h0);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if ((write_en | read_en) != 8'h00 || data_in != 32'h0) extra++;
    end
    check("latency", 32'(lat), 32'd2);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_error", 32'(rsp_error), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if ((write_en | read_en) != 8'h00 || data_in != 32'h0) extra++;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    if ((write_en | read_en) != 8'h00) extra++;
    check("extra_strobes", 32'(extra), 32'd0);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rsp_error", 32'(rsp_error), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          hold;
    bit          second;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int k = 0; k < P2; k++) model_regs[k] = 32'h0;
    tbl[0]  = '{1'b1, 8'h00, 32'h0000_1234, 32'h0000_0000, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b1, 8'h02, 32'h0000_05A3, 32'h0000_0000, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b0, 8'h02, 32'h0,         32'h0000_05A3, 1'b0, 0, 1'b0};
    tbl[3]  = '{1'b0, 8'h04, 32'h0,         32'h0000_00AA, 1'b0, 0, 1'b0};
    tbl[4]  = '{1'b0, 8'h04, 32'h0,         32'h0000_00BB, 1'b0, 0, 1'b0};
    tbl[5]  = '{1'b1, 8'h07, 32'h0000_CAFE, 32'h0000_0000, 1'b1, 0, 1'b0};
    tbl[6]  = '{1'b0, 8'hFF, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0};
    tbl[7]  = '{1'b0, 8'h05, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 32'h0,         32'h0000_1234, 1'b0, 0, 1'b0};
    tbl[9]  = '{1'b1, 8'h03, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b0};
    tbl[10] = '{1'b0, 8'h03, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b0};
    tbl[11] = '{1'b0, 8'h08, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0};
    tbl[12] = '{1'b0, 8'h80, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0};
    tbl[13] = '{1'b0, 8'h02, 32'h0,         32'h0000_05A3, 1'b0, 10, 1'b1};

    reset     = 1'b0;
    map_init  = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    map_init = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_strobes", 32'({write_en, read_en}), 32'd0);
    check("rst_data_in", data_in, 32'h0);

    // Release reset with a command that is dropped before it can be accepted.
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 32'h0000_9999;
    #1 check("rel_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rel_cmd_ready_1", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("dropped_cmd_strobe", 32'({write_en, read_en}), 32'd0);
    check("dropped_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
          tbl[i].hold, tbl[i].second);
      model_update(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
    end

    // Reset asserted in the ACCESS cycle of a write to address 1.
    cmd_write = 1'b1;
    cmd_addr  = 8'h01;
    cmd_wdata = 32'h5555_AAAA;
    cmd_valid = 1'b1;
    for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    check("rst6_accept_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst6_write_en", 32'(write_en), 32'h02);
    #1 reset = 1'b0;
    #1;
    check("rst6_async_we", 32'(write_en), 32'd0);
    check("rst6_async_data_in", data_in, 32'h0);
    check("rst6_async_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst6_cmd_ready", 32'(cmd_ready), 32'd1);
    txn(1'b0, 8'h01, 32'h0, model_rdata(1'b0, 8'h01), 1'b0, 0, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      bit          wr;
      logic [7:0]  a;
      logic [31:0] wd;
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      wd = $urandom;
      txn(wr, a, wd, model_rdata(wr, a), (a >= REGS), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      model_update(wr, a, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
